// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction SRAM request/response, decode handshake,
// redirect, and the registered IF/ID word handed to decode.
interface if_stage_if;
    logic        ID_allowin;
    logic        flush;
    logic [31:0] pc_real;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [64:0] IF_to_ID_zip;

    // Fetch stage side
    modport master (
        input  ID_allowin,
        input  flush,
        input  pc_real,
        input  inst_sram_rdata,
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        output IF_to_ID_zip
    );

    // Decode / memory side
    modport slave (
        output ID_allowin,
        output flush,
        output pc_real,
        output inst_sram_rdata,
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  IF_to_ID_zip
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues nextpc to the instruction SRAM, holds the
// returned word across decode stalls, predicts b/bl always taken and
// conditional branches backward-taken/forward-not-taken, and accepts
// decode redirects with priority over everything else.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);

    localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] inst_buf;

    logic [31:0]        fs_inst;
    logic               fs_allowin;
    logic [5:0]         op;
    logic               is_b;
    logic               is_bl;
    logic               is_cond;
    logic               predict;
    logic signed [31:0] offs_long;
    logic signed [31:0] offs_cond;
    logic [31:0]        pred_target;
    logic [31:0]        nextpc;

    // The SRAM word is only valid for one cycle, so a stalled word is read from the buffer.
    assign fs_inst    = buf_valid ? inst_buf : bus.inst_sram_rdata;
    assign fs_allowin = ~fs_valid | bus.ID_allowin;

    // Branch decode, static prediction and next fetch address
    always_comb begin
        op          = fs_inst[31:26];
        is_b        = (op == 6'h14);
        is_bl       = (op == 6'h15);
        is_cond     = (op >= 6'h16) && (op <= 6'h1b);
        // Conditional offset sign bit doubles as the backward-taken hint; jirl is never predicted.
        predict     = fs_valid & (is_b | is_bl | (is_cond & fs_inst[25]));
        offs_long   = {{4{fs_inst[9]}}, fs_inst[9:0], fs_inst[25:10], 2'b00};
        offs_cond   = {{14{fs_inst[25]}}, fs_inst[25:10], 2'b00};
        pred_target = fs_pc + ((is_b | is_bl) ? $unsigned(offs_long) : $unsigned(offs_cond));
        if (bus.flush) begin
            nextpc = bus.pc_real;
        end else if (predict) begin
            nextpc = pred_target;
        end else begin
            nextpc = fs_pc + 32'd4;
        end
    end

    assign bus.inst_sram_en    = ~rst & (fs_allowin | bus.flush);
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_wdata = 32'b0;

    // Fetch PC/valid: redirect wins, otherwise advance whenever the stage can accept
    always_ff @(posedge clk) begin
        if (rst) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC;
        end else if (bus.flush) begin
            fs_valid <= 1'b1;
            fs_pc    <= bus.pc_real;
        end else if (fs_allowin) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end
    end

    // Stall buffer: capture the SRAM word on the first stalled cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            inst_buf  <= 32'b0;
        end else if (bus.flush || fs_allowin) begin
            buf_valid <= 1'b0;
        end else if (fs_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= bus.inst_sram_rdata;
        end
    end

    // IF/ID register: load a word or a bubble when decode accepts, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.IF_to_ID_zip <= 65'b0;
        end else if (bus.ID_allowin) begin
            if (fs_valid && !bus.flush) begin
                bus.IF_to_ID_zip <= {predict, fs_inst, fs_pc};
            end else begin
                bus.IF_to_ID_zip <= 65'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset release, sequential fetch, b/bne
// prediction, stall buffering, redirect during stall, and mid-run reset.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] NOP    = 32'h0340_0000;
    localparam logic [31:0] B_P40  = 32'h5000_4000;   // b +0x40
    localparam logic [31:0] B_M30  = 32'h53FF_D3FF;   // b -0x30
    localparam logic [31:0] BNE_BK = 32'h5FFF_F800;   // bne -8, inst[25]=1
    localparam logic [31:0] BNE_FW = 32'h5DFF_F800;   // same with inst[25]=0
    localparam logic [31:0] W1     = 32'h0280_0421;
    localparam logic [31:0] W2     = 32'h0280_0842;

    int n_cmp = 0;
    int n_bad = 0;

    // Count one comparison and report it if it differs
    task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic a, input logic f, input logic [31:0] pr, input logic [31:0] rd);
        bus.ID_allowin      = a;
        bus.flush           = f;
        bus.pc_real         = pr;
        bus.inst_sram_rdata = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic en, input logic [31:0] addr);
        check_eq({tag, ".en"}, {64'b0, bus.inst_sram_en}, {64'b0, en});
        if (en) check_eq({tag, ".addr"}, {33'b0, bus.inst_sram_addr}, {33'b0, addr});
    endtask

    task automatic chk_fs(input string tag, input logic v, input logic [31:0] pc, input logic bv);
        check_eq({tag, ".fs_valid"}, {64'b0, dut.fs_valid}, {64'b0, v});
        check_eq({tag, ".fs_pc"}, {33'b0, dut.fs_pc}, {33'b0, pc});
        check_eq({tag, ".buf_valid"}, {64'b0, dut.buf_valid}, {64'b0, bv});
    endtask

    task automatic chk_zip(input string tag, input logic p, input logic [31:0] inst, input logic [31:0] pc);
        check_eq({tag, ".zip"}, bus.IF_to_ID_zip, {p, inst, pc});
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b1, 1'b0, 32'h0, NOP);
        tick();
        tick();
        // reset state
        chk_fs("rst", 1'b0, 32'h1BFF_FFFC, 1'b0);
        chk_fetch("rst", 1'b0, 32'h0);
        chk_zip("rst", 1'b0, 32'h0, 32'h0);
        check_eq("rst.we", {61'b0, bus.inst_sram_we}, 65'b0);
        check_eq("rst.wdata", {33'b0, bus.inst_sram_wdata}, 65'b0);

        // A: first fetch after reset release
        rst = 1'b0;
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fetch("A", 1'b1, 32'h1C00_0000);
        tick();
        // B
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fs("B", 1'b1, 32'h1C00_0000, 1'b0);
        chk_fetch("B", 1'b1, 32'h1C00_0004);
        chk_zip("B", 1'b0, 32'h0, 32'h0);
        tick();
        // C
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fs("C", 1'b1, 32'h1C00_0004, 1'b0);
        chk_fetch("C", 1'b1, 32'h1C00_0008);
        chk_zip("C", 1'b0, NOP, 32'h1C00_0000);
        tick();
        // D
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fetch("D", 1'b1, 32'h1C00_000C);
        chk_zip("D", 1'b0, NOP, 32'h1C00_0004);
        tick();
        // E
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fetch("E", 1'b1, 32'h1C00_0010);
        tick();
        // F: b +0x40 at 0x1C000010
        set_in(1'b1, 1'b0, 32'h0, B_P40);
        chk_fs("F", 1'b1, 32'h1C00_0010, 1'b0);
        chk_fetch("F", 1'b1, 32'h1C00_0050);
        tick();
        // G: no bubble; backward b -0x30 at 0x1C000050
        set_in(1'b1, 1'b0, 32'h0, B_M30);
        chk_fs("G", 1'b1, 32'h1C00_0050, 1'b0);
        chk_zip("G", 1'b1, B_P40, 32'h1C00_0010);
        chk_fetch("G", 1'b1, 32'h1C00_0020);
        tick();
        // H: bne backward at 0x1C000020
        set_in(1'b1, 1'b0, 32'h0, BNE_BK);
        chk_fs("H", 1'b1, 32'h1C00_0020, 1'b0);
        chk_zip("H", 1'b1, B_M30, 32'h1C00_0050);
        chk_fetch("H", 1'b1, 32'h1C00_0018);
        tick();
        // I: redirect back to 0x1C000020
        set_in(1'b1, 1'b1, 32'h1C00_0020, NOP);
        chk_fs("I", 1'b1, 32'h1C00_0018, 1'b0);
        chk_zip("I", 1'b1, BNE_BK, 32'h1C00_0020);
        chk_fetch("I", 1'b1, 32'h1C00_0020);
        tick();
        // J: bubble in zip; bne with inst[25]=0 not taken
        set_in(1'b1, 1'b0, 32'h0, BNE_FW);
        chk_fs("J", 1'b1, 32'h1C00_0020, 1'b0);
        chk_zip("J", 1'b0, 32'h0, 32'h0);
        chk_fetch("J", 1'b1, 32'h1C00_0024);
        tick();
        // K: stall cycle 1, W1 returned
        set_in(1'b0, 1'b0, 32'h0, W1);
        chk_fs("K", 1'b1, 32'h1C00_0024, 1'b0);
        chk_zip("K", 1'b0, BNE_FW, 32'h1C00_0020);
        chk_fetch("K", 1'b0, 32'h0);
        tick();
        // L: stall cycle 2, garbage on SRAM
        set_in(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        chk_fs("L", 1'b1, 32'h1C00_0024, 1'b1);
        chk_fetch("L", 1'b0, 32'h0);
        tick();
        // M: stall cycle 3
        set_in(1'b0, 1'b0, 32'h0, 32'h1234_5678);
        chk_fs("M", 1'b1, 32'h1C00_0024, 1'b1);
        chk_zip("M", 1'b0, BNE_FW, 32'h1C00_0020);
        chk_fetch("M", 1'b0, 32'h0);
        tick();
        // N: release
        set_in(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D);
        chk_fetch("N", 1'b1, 32'h1C00_0028);
        tick();
        // O: buffered word delivered; start a new stall with W2
        set_in(1'b0, 1'b0, 32'h0, W2);
        chk_zip("O", 1'b0, W1, 32'h1C00_0024);
        chk_fs("O", 1'b1, 32'h1C00_0028, 1'b0);
        chk_fetch("O", 1'b0, 32'h0);
        tick();
        // P: redirect during stall with decode accepting
        set_in(1'b1, 1'b1, 32'h1C00_0100, 32'h0);
        chk_fs("P", 1'b1, 32'h1C00_0028, 1'b1);
        chk_fetch("P", 1'b1, 32'h1C00_0100);
        tick();
        // Q
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fs("Q", 1'b1, 32'h1C00_0100, 1'b0);
        chk_zip("Q", 1'b0, 32'h0, 32'h0);
        chk_fetch("Q", 1'b1, 32'h1C00_0104);
        tick();
        // R: stall to fill the buffer
        set_in(1'b0, 1'b0, 32'h0, W1);
        chk_zip("R", 1'b0, NOP, 32'h1C00_0100);
        tick();
        // S: reset while buffered
        check_eq("S.buf_valid", {64'b0, dut.buf_valid}, 65'd1);
        check_eq("S.inst_buf", {33'b0, dut.inst_buf}, {33'b0, W1});
        rst = 1'b1;
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fetch("S", 1'b0, 32'h0);
        tick();
        // T: reset values restored
        chk_fs("T", 1'b0, 32'h1BFF_FFFC, 1'b0);
        check_eq("T.inst_buf", {33'b0, dut.inst_buf}, 65'b0);
        chk_zip("T", 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        set_in(1'b1, 1'b0, 32'h0, NOP);
        chk_fetch("T", 1'b1, 32'h1C00_0000);
        tick();
        // U
        chk_fs("U", 1'b1, 32'h1C00_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
